// File: rtl/jk_count_ctrl.sv
// Sequencer that drives the J/K inputs of an external JK flip-flop bank so the bank behaves
// as a programmable modulo up/down counter with load, clear, stop and terminal-count pulse.
module jk_count_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             cmd_ready,
  output logic             running,
  output logic             tc_pulse
);

  typedef enum logic [1:0] {StIdle, StRun, StLoad, StClear} state_e;

  localparam logic [2:0] OpStop    = 3'd0;
  localparam logic [2:0] OpRunUp   = 3'd1;
  localparam logic [2:0] OpRunDown = 3'd2;
  localparam logic [2:0] OpLoad    = 3'd3;
  localparam logic [2:0] OpClear   = 3'd4;

  state_e           state_q;
  logic [WIDTH-1:0] mod_q;
  logic             dir_q;
  logic             resume_q;
  logic [WIDTH-1:0] ld_q;
  logic             tc_q;

  logic             wrap;
  logic [WIDTH-1:0] next_cnt;

  // Wrap condition also covers a loaded value above the modulus and mod_q == 0.
  always_comb begin
    wrap     = 1'b0;
    next_cnt = '0;
    if (!dir_q) begin
      wrap     = (q_in >= mod_q);
      next_cnt = wrap ? '0 : q_in + WIDTH'(1);
    end else begin
      wrap     = (q_in == '0) || (q_in > mod_q);
      next_cnt = wrap ? mod_q : q_in - WIDTH'(1);
    end
  end

  always_comb begin
    j_out = '0;
    k_out = '0;
    unique case (state_q)
      StLoad: begin
        j_out = ld_q;
        k_out = ~ld_q;
      end
      StClear: k_out = '1;
      // Toggle only the bits that differ between current and next count.
      StRun: begin
        j_out = q_in ^ next_cnt;
        k_out = q_in ^ next_cnt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      mod_q    <= '1;
      dir_q    <= 1'b0;
      resume_q <= 1'b0;
      ld_q     <= '0;
      tc_q     <= 1'b0;
    end else begin
      tc_q <= (state_q == StRun) && wrap;
      unique case (state_q)
        StIdle, StRun: begin
          if (cmd_valid) begin
            case (cmd_op)
              OpStop: state_q <= StIdle;
              OpRunUp, OpRunDown: begin
                state_q <= StRun;
                mod_q   <= cmd_data;
                dir_q   <= cmd_op[1];
              end
              OpLoad: begin
                state_q  <= StLoad;
                ld_q     <= cmd_data;
                resume_q <= (state_q == StRun);
              end
              OpClear: begin
                state_q  <= StClear;
                resume_q <= (state_q == StRun);
              end
              default: ;
            endcase
          end
        end
        StLoad, StClear: state_q <= resume_q ? StRun : StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready = (state_q == StIdle) || (state_q == StRun);
  assign running   = (state_q == StRun);
  assign tc_pulse  = tc_q;

endmodule

// File: tb/tb_jk_count_ctrl.sv
// Directed bench for jk_count_ctrl with a behavioural JK flip-flop bank closing the loop.
module tb_jk_count_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] q_bank;
  logic [3:0] j_out, k_out;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic       cmd_ready, running, tc_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  jk_count_ctrl #(.WIDTH(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .q_in     (q_bank),
    .j_out    (j_out),
    .k_out    (k_out),
    .cmd_valid(cmd_valid),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .cmd_ready(cmd_ready),
    .running  (running),
    .tc_pulse (tc_pulse)
  );

  always #5 clock = ~clock;

  // JK bank: Q+ = J & ~Q | ~K & Q
  always_ff @(posedge clock or posedge reset) begin
    if (reset) q_bank <= '0;
    else       q_bank <= (j_out & ~q_bank) | (~k_out & q_bank);
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    step();
    cmd_valid = 1'b0;
    cmd_op    = 3'd5;
    cmd_data  = '0;
  endtask

  initial begin
    logic [3:0] up_seq[7];
    logic       up_tc[7];
    logic [3:0] dn_seq[5];
    logic       dn_tc[5];
    up_seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1};
    up_tc  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    dn_seq = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd3};
    dn_tc  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd5; cmd_data = '0;
    #2;
    check("rst_ready", 8'(cmd_ready), 8'd1);
    check("rst_running", 8'(running), 8'd0);
    check("rst_j", 8'(j_out), 8'd0);
    check("rst_k", 8'(k_out), 8'd0);
    check("rst_tc", 8'(tc_pulse), 8'd0);
    #10 reset = 1'b0;

    // Count up modulo 5
    issue(3'd1, 4'd5);
    check("up_running", 8'(running), 8'd1);
    check("up_q0", 8'(q_bank), 8'd0);
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("up_q[%0d]", i), 8'(q_bank), 8'(up_seq[i]));
      check($sformatf("up_tc[%0d]", i), 8'(tc_pulse), 8'(up_tc[i]));
    end

    // STOP: the accepting edge still counts 1->2, then the bank holds
    issue(3'd0, 4'd0);
    check("stop_running", 8'(running), 8'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("stop_hold[%0d]", i), 8'(q_bank), 8'd2);
    end
    check("stop_j", 8'(j_out), 8'd0);
    check("stop_k", 8'(k_out), 8'd0);

    // LOAD 7 from IDLE, then CLEAR
    issue(3'd3, 4'd7);
    check("ld_idle_ready", 8'(cmd_ready), 8'd0);
    step();
    check("ld_idle_q", 8'(q_bank), 8'd7);
    check("ld_idle_running", 8'(running), 8'd0);
    issue(3'd4, 4'd0);
    check("clr_ready", 8'(cmd_ready), 8'd0);
    check("clr_j", 8'(j_out), 8'd0);
    check("clr_k", 8'(k_out), 8'd15);
    step();
    check("clr_q", 8'(q_bank), 8'd0);
    check("clr_running", 8'(running), 8'd0);
    check("clr_after_j", 8'(j_out), 8'd0);
    check("clr_after_k", 8'(k_out), 8'd0);
    check("clr_after_ready", 8'(cmd_ready), 8'd1);

    // Count down modulo 3 from 0
    issue(3'd2, 4'd3);
    check("dn_q0", 8'(q_bank), 8'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("dn_q[%0d]", i), 8'(q_bank), 8'(dn_seq[i]));
      check($sformatf("dn_tc[%0d]", i), 8'(tc_pulse), 8'(dn_tc[i]));
    end

    // RUN_UP while running down: edge counts 3->2 down, new direction takes effect next edge
    issue(3'd1, 4'd5);
    check("rerun_q", 8'(q_bank), 8'd2);
    check("rerun_running", 8'(running), 8'd1);

    // LOAD 9 while running up at q=2
    issue(3'd3, 4'd9);
    check("ld_run_q", 8'(q_bank), 8'd3);
    check("ld_run_ready", 8'(cmd_ready), 8'd0);
    check("ld_run_j", 8'(j_out), 8'd9);
    check("ld_run_k", 8'(k_out), 8'd6);
    step();
    check("ld_run_q9", 8'(q_bank), 8'd9);
    check("ld_run_ready2", 8'(cmd_ready), 8'd1);
    check("ld_run_tc9", 8'(tc_pulse), 8'd0);
    step();
    check("ld_wrap_q", 8'(q_bank), 8'd0);
    check("ld_wrap_tc", 8'(tc_pulse), 8'd1);
    step();
    check("ld_post_q", 8'(q_bank), 8'd1);

    // NOP ops 5..7 while running: no state change, counting continues
    for (int i = 0; i < 3; i++) begin
      issue(3'(5 + i), 4'd0);
      check($sformatf("nop_q[%0d]", i), 8'(q_bank), 8'(2 + i));
      check($sformatf("nop_running[%0d]", i), 8'(running), 8'd1);
    end

    // Reset while in LOAD (accepting edge counts 4->5)
    issue(3'd3, 4'd9);
    check("pre_rst_q", 8'(q_bank), 8'd5);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_ready", 8'(cmd_ready), 8'd1);
    check("mid_rst_running", 8'(running), 8'd0);
    check("mid_rst_j", 8'(j_out), 8'd0);
    check("mid_rst_k", 8'(k_out), 8'd0);
    check("mid_rst_q", 8'(q_bank), 8'd0);
    #1 reset = 1'b0;

    // RUN_UP mod=0 accepted at first edge after release
    issue(3'd1, 4'd0);
    check("m0_running", 8'(running), 8'd1);
    check("m0_tc0", 8'(tc_pulse), 8'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("m0_q[%0d]", i), 8'(q_bank), 8'd0);
      check($sformatf("m0_tc[%0d]", i), 8'(tc_pulse), 8'd1);
    end

    // NOP from IDLE
    issue(3'd0, 4'd0);
    issue(3'd6, 4'd3);
    check("nop_idle_running", 8'(running), 8'd0);
    check("nop_idle_ready", 8'(cmd_ready), 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jk_count_ctrl.md
# jk_count_ctrl

Sequencer for an external bank of `WIDTH` JK flip-flops sharing `clock` and `reset`. It turns a small command interface into per-bit J/K drive, making the bank behave as a programmable modulo up/down counter with load, clear, stop and a terminal-count pulse. It reads the bank's `q` outputs back and is the only driver of the bank's J/K inputs.

## Interface
- `WIDTH`, default 4: counter and flip-flop bank width.
- `clock`  in  1  rising-edge clock, shared with the JK bank.
- `reset`  in  1  asynchronous, active-high; also resets the JK bank to 0.
- `q_in`  in  WIDTH  current JK bank outputs.
- `j_out`  out  WIDTH  J inputs of the bank, combinational.
- `k_out`  out  WIDTH  K inputs of the bank, combinational.
- `cmd_valid`  in  1  command present.
- `cmd_op`  in  3  0 STOP, 1 RUN_UP, 2 RUN_DOWN, 3 LOAD, 4 CLEAR, 5–7 NOP.
- `cmd_data`  in  WIDTH  modulus for RUN_*; load value for LOAD; ignored otherwise.
- `cmd_ready`  out  1  command accepted at an edge where `cmd_valid && cmd_ready`.
- `running`  out  1  high in RUN state.
- `tc_pulse`  out  1  one-cycle terminal-count (wrap) indication.

## Operation
- States: IDLE, RUN, LOAD, CLEAR. Registers: `state`, `mod_r` (WIDTH), `dir_r` (0 up, 1 down), `resume_r`, `ld_r` (WIDTH), `tc_pulse`.
- Reset: state IDLE, `mod_r` all ones, `dir_r`=0, `resume_r`=0, `ld_r`=0, `tc_pulse`=0, `cmd_ready`=1, `running`=0, `j_out`=`k_out`=0.
- `cmd_ready` = 1 in IDLE and RUN; 0 in LOAD and CLEAR.
- Accepted commands in IDLE or RUN:
  - STOP → IDLE.
  - RUN_UP/RUN_DOWN → RUN; `mod_r`←`cmd_data`; `dir_r`←op bit.
  - LOAD → LOAD; `ld_r`←`cmd_data`; `resume_r`←(state==RUN).
  - CLEAR → CLEAR; `resume_r`←(state==RUN).
  - NOP → no state change.
- LOAD and CLEAR last exactly one cycle, then go to RUN if `resume_r`, else IDLE.
- J/K drive:
  - IDLE: J=K=0 (hold).
  - LOAD: J=`ld_r`, K=~`ld_r`.
  - CLEAR: J=0, K=all ones.
  - RUN: J=K=`q_in ^ next`, using toggle mode on the bits that change.
- `next` in RUN:
  - Up: `q_in >= mod_r` → 0, else `q_in+1`.
  - Down: `q_in==0` or `q_in > mod_r` → `mod_r`, else `q_in-1`.
  - Arithmetic is WIDTH bits, unsigned.
- `mod_r`=0: `next`=0 every cycle, with a tc every cycle.
- A loaded value above `mod_r` wraps on the next RUN edge: up goes to 0, down goes to `mod_r`.

## Timing
- `tc_pulse` is registered. At each edge it is set to (state==RUN && `next` is the wrap value): 0 for up, `mod_r` for down. So `tc_pulse` is high during the same cycle the bank first shows the wrapped value, and low otherwise.
- Command accepted at edge N:
  - The new state's J/K drive is present during cycle N→N+1.
  - The bank shows the result after edge N+1.
  - A counter already running is not advanced at edge N+1 by LOAD/CLEAR; it resumes counting from edge N+2.
- RUN accepted at edge N: the first count occurs at edge N+1.
- A STOP accepted at edge N leaves `q_in` held from edge N+1 on.
- A RUN issued while already running updates `mod_r`/`dir_r` with no bubble.
- `reset` mid-LOAD/CLEAR/RUN returns immediately to reset values, and the bank also goes to 0. The pending operation is dropped.
- `cmd_valid` while `cmd_ready`=0 is not accepted; the requester holds it until the next cycle.

## Test plan
- Reset, then RUN_UP mod=5 → `q_in` sequence 1,2,3,4,5,0,1; `tc_pulse` high only in the cycles showing 0; `running`=1.
- RUN_DOWN mod=3 from 0 → `q_in` sequence 3,2,1,0,3; `tc_pulse` in the cycles showing 3.
- While running up at `q`=2, LOAD 9 (mod=5):
  - `cmd_ready` is low for one cycle.
  - The bank shows 9 and holds 9 for one edge.
  - It then wraps to 0 with `tc_pulse`.
- IDLE with `q`=7, CLEAR → 0 after 2 edges, state IDLE, J=K=0 afterwards; STOP mid-run → `q` holds for ≥5 cycles.
- Assert `reset` while in the LOAD state:
  - All outputs take their reset values asynchronously and `q_in`=0.
  - The next command is accepted at the first edge after release.
- RUN_UP mod=0 → `q` stays 0 and `tc_pulse` is high every cycle; NOP ops 5–7 → no state change.
